uart_sram_tx_interface: RTL

- Reverse-direction partner of the UART receive path: reads a block of 16-bit words from SRAM and sends them out on UART_TX_O as 8N1 bytes, high byte first.
- Used to dump decoded image regions back to the host PC.
- The top level gives it SRAM port ownership in a dedicated top state and routes its serial output to UART_TX_O in place of the constant 1.

---
 rtl/uart_sram_tx_interface_pkg.sv | 29 ++
 rtl/uart_sram_tx_interface_byte_tx.sv | 101 ++++++++++
 rtl/uart_sram_tx_interface.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types for the SRAM-to-UART dump path.
// Covers the block FSM and the byte serializer.
package uart_sram_tx_interface_pkg;

  localparam int ADDR_W = 18;
  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    S_TXI_IDLE,
    S_TXI_WAIT,
    S_TXI_SEND_HI,
    S_TXI_SEND_LO,
    S_TXI_FLUSH
  } tx_if_state_type;

  typedef enum logic [1:0] {
    S_UTX_IDLE,
    S_UTX_START,
    S_UTX_DATA,
    S_UTX_STOP
  } utx_state_type;

  function automatic logic [ADDR_W-1:0] addr_next(
    input logic [ADDR_W-1:0] a
  );
    return a + 18'd1;
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_byte_tx.sv
// 8N1 byte serializer; Ready also rises in the last stop-bit
// cycle so back-to-back frames need no idle gap.
module uart_byte_tx
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       Ready,
  output logic       TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  utx_state_type state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);
  assign Ready   = (state_q == S_UTX_IDLE) ||
                   ((state_q == S_UTX_STOP) && bit_end);
  assign TX      = tx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      S_UTX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (Load) begin
          state_d = S_UTX_START;
          shift_d = Data;
          tx_d    = 1'b0;
        end
      end
      S_UTX_START: begin
        if (bit_end) begin
          state_d = S_UTX_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_UTX_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_UTX_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_UTX_STOP: begin
        if (bit_end) begin
          if (Load) begin
            state_d = S_UTX_START;
            shift_d = Data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_UTX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_UTX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_UTX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of SRAM words and streams them out on UART,
// high byte first, prefetching the next word during the low byte.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SRAM_LATENCY = 2
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Start_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  input  logic [WORD_W-1:0] SRAM_read_data,
  output logic              SRAM_we_n,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  localparam int LW = (SRAM_LATENCY < 1) ? 1 :
                      $clog2(SRAM_LATENCY + 1);
  localparam logic [LW-1:0] LAT = LW'(SRAM_LATENCY);

  tx_if_state_type   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] pre_q, pre_d;
  logic              pre_vld_q, pre_vld_d;
  logic              pf_busy_q, pf_busy_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ld;
  logic [7:0]        ld_byte;
  logic              tx_ready;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .Load      (ld),
    .Data      (ld_byte),
    .Ready     (tx_ready),
    .TX        (UART_TX_O)
  );

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    word_d    = word_q;
    pre_d     = pre_q;
    pre_vld_d = pre_vld_q;
    pf_busy_d = pf_busy_q;
    lat_d     = lat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    ld_byte   = 8'h00;

    // background prefetch of the next word
    if (pf_busy_q) begin
      if (lat_q == LAT) begin
        pre_d     = SRAM_read_data;
        pre_vld_d = 1'b1;
        pf_busy_d = 1'b0;
      end else begin
        lat_d = lat_q + 1'b1;
      end
    end

    unique case (state_q)
      S_TXI_IDLE: begin
        if (Start && !done_q) begin
          if (Word_count != '0) begin
            addr_d  = Start_address;
            rem_d   = Word_count;
            busy_d  = 1'b1;
            lat_d   = '0;
            state_d = S_TXI_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_TXI_WAIT: begin
        if (lat_q == LAT) begin
          word_d  = SRAM_read_data;
          state_d = S_TXI_SEND_HI;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_TXI_SEND_HI: begin
        if (tx_ready && !pf_busy_q) begin
          ld = 1'b1;
          if (pre_vld_q) begin
            ld_byte   = pre_q[15:8];
            word_d    = pre_q;
            pre_vld_d = 1'b0;
          end else begin
            ld_byte = word_q[15:8];
          end
          state_d = S_TXI_SEND_LO;
        end
      end
      S_TXI_SEND_LO: begin
        if (tx_ready) begin
          ld      = 1'b1;
          ld_byte = word_q[7:0];
          rem_d   = rem_q - 18'd1;
          if (rem_q > 18'd1) begin
            addr_d    = addr_next(addr_q);
            pf_busy_d = 1'b1;
            lat_d     = '0;
            state_d   = S_TXI_SEND_HI;
          end else begin
            state_d = S_TXI_FLUSH;
          end
        end
      end
      S_TXI_FLUSH: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_TXI_IDLE;
        end
      end
      default: begin
        state_d = S_TXI_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_TXI_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      word_q    <= '0;
      pre_q     <= '0;
      pre_vld_q <= 1'b0;
      pf_busy_q <= 1'b0;
      lat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      word_q    <= word_d;
      pre_q     <= pre_d;
      pre_vld_q <= pre_vld_d;
      pf_busy_q <= pf_busy_d;
      lat_q     <= lat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
